vga_text_write_arb: RTL and testbench

- Shares the VGA text console's single character-write port (char[7:0] plus edge-sensitive en) between two byte sources, A and B (e.g. UART RX and keyboard).
- Accepts bytes through valid/ready handshakes and arbitrates round-robin.
- Buffers accepted bytes in a small FIFO.
- A sequencer replays the FIFO as clean en pulses, with char stable across each pulse and the low gap after it, so the console's rising-edge detector sees exactly one write per byte.

---
 rtl/vga_text_write_arb.sv | 141 ++++++++++++++
 tb/tb_vga_text_write_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_write_arb.sv
// Round-robin arbiter that merges two byte sources into one VGA text console write port.
// Optional macro VGA_TEXT_CRLF_COLLAPSE_EN drops the LF that immediately follows an emitted CR.
module vga_text_write_arb #(
    parameter int FIFO_DEPTH   = 8,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    a_data,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [7:0]                    b_data,
    input  logic                          b_valid,
    output logic                          b_ready,
    output logic [7:0]                    char,
    output logic                          en,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int CMAX  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             rr_b;
    logic             space, a_fire, b_fire, push, pop, drop, emit;
    logic [7:0]       push_data, head;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    // Space comes from the registered count, so a same-cycle pop never frees a slot.
    // reset_n gating keeps both readies low for the whole time reset is held.
    always_comb begin
        space     = (fifo_count < CW'(FIFO_DEPTH));
        a_ready   = reset_n && space && a_valid && (!b_valid || !rr_b);
        b_ready   = reset_n && space && b_valid && (!a_valid || rr_b);
        a_fire    = a_valid && a_ready;
        b_fire    = b_valid && b_ready;
        push      = a_fire || b_fire;
        push_data = a_fire ? a_data : b_data;
        head      = mem[rd_ptr];
        pop       = (state == S_IDLE) && (fifo_count != '0);
        emit      = pop && !drop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_b <= 1'b0;
        end else if (a_fire) begin
            rr_b <= 1'b1;
        end else if (b_fire) begin
            rr_b <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef VGA_TEXT_CRLF_COLLAPSE_EN
    logic [7:0] last_char;

    // Cleared after a drop so a later LF is treated as a genuine newline.
    assign drop = pop && (head == 8'h0A) && (last_char == 8'h0D);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_char <= 8'h00;
        end else if (emit) begin
            last_char <= head;
        end else if (drop) begin
            last_char <= 8'h00;
        end
    end
`else
    assign drop = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            char  <= 8'h00;
            en    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (emit) begin
                        char  <= head;
                        en    <= 1'b1;
                        cnt   <= CNT_W'(PULSE_CYCLES - 1);
                        state <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (cnt == '0) begin
                        en    <= 1'b0;
                        cnt   <= CNT_W'(GAP_CYCLES - 1);
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == '0) state <= S_IDLE;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                default: begin
                    en    <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_vga_text_write_arb.sv
// Directed bench for vga_text_write_arb: reset, timing, arbitration, backpressure, CRLF, reset mid-pulse.
module tb_vga_text_write_arb;
    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic       a_ready, b_ready, en, busy;
    logic [7:0] ch;
    logic [3:0] fifo_count;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] emitted[$];
    logic       en_q = 1'b0;

    vga_text_write_arb dut (
        .clk(clk), .reset_n(reset_n),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .char(ch), .en(en), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Records the char on every rising edge of en.
    always @(negedge clk) begin
        if (en && !en_q) emitted.push_back(ch);
        en_q <= en;
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        reset_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        emitted.delete();
    endtask

    // Entered and left at edge+1; holds valid until the byte is accepted.
    task automatic send(input bit src, input logic [7:0] d);
        int t = 0;
        if (src == 1'b0) begin a_valid = 1'b1; a_data = d; end
        else             begin b_valid = 1'b1; b_data = d; end
        #1;
        while (!((src == 1'b0) ? a_ready : b_ready) && t < 200) begin
            @(posedge clk); #2; t++;
        end
        if (t >= 200) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout src=%0d data=%h", src, d);
        end
        @(posedge clk); #1;
        if (src == 1'b0) a_valid = 1'b0; else b_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        #1;
        while (busy && t < 300) begin @(posedge clk); #2; t++; end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_timeout busy=%b want 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        reset_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h11; b_data = 8'h22;
        #3;
        n_cmp++; if (ch !== 8'h00)       begin n_fail++; $display("FAIL rst_char got %h want 00", ch); end
        n_cmp++; if (en !== 1'b0)        begin n_fail++; $display("FAIL rst_en got %b want 0", en); end
        n_cmp++; if (a_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_a_ready got %b want 0", a_ready); end
        n_cmp++; if (b_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_b_ready got %b want 0", b_ready); end
        n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", fifo_count); end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        emitted.delete();
    endtask

    task automatic test_single_byte();
        logic [4:0] exp_en   = 5'b00011;  // bit k = en after edge t+1+k
        logic [4:0] exp_busy = 5'b01111;
        apply_reset();
        a_valid = 1'b1; a_data = 8'h41;
        #1;
        n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL single_a_ready got %b want 1", a_ready); end
        @(posedge clk); #1;
        a_valid = 1'b0;
        #1;
        n_cmp++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL single_count_t got %0d want 1", fifo_count); end
        n_cmp++; if (en !== 1'b0)         begin n_fail++; $display("FAIL single_en_t got %b want 0", en); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            n_cmp++; if (en !== exp_en[k])     begin n_fail++; $display("FAIL single_en[%0d] got %b want %b", k, en, exp_en[k]); end
            n_cmp++; if (busy !== exp_busy[k]) begin n_fail++; $display("FAIL single_busy[%0d] got %b want %b", k, busy, exp_busy[k]); end
            n_cmp++; if (ch !== 8'h41)         begin n_fail++; $display("FAIL single_char[%0d] got %h want 41", k, ch); end
        end
        n_cmp++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL single_count_end got %0d want 0", fifo_count); end
        n_cmp++; if (emitted.size() != 1) begin n_fail++; $display("FAIL single_pulses got %0d want 1", emitted.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        bit   order[$];
        logic [7:0] exp[$] = '{8'h31, 8'h32, 8'h31, 8'h32, 8'h31, 8'h32};
        int n = 0, t = 0, both = 0;
        apply_reset();
        a_valid = 1'b1; a_data = 8'h31; b_valid = 1'b1; b_data = 8'h32;
        while (n < 6 && t < 100) begin
            #1;
            if (a_ready && b_ready) both++;
            if (a_ready) order.push_back(1'b0);
            if (b_ready) order.push_back(1'b1);
            if (a_ready || b_ready) n++;
            @(posedge clk); #1; t++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        n_cmp++; if (both != 0) begin n_fail++; $display("FAIL cont_dual_grant got %0d want 0", both); end
        n_cmp++; if (order.size() != 6) begin n_fail++; $display("FAIL cont_accepts got %0d want 6", order.size()); end
        for (int i = 0; i < 6 && i < order.size(); i++) begin
            n_cmp++; if (order[i] !== i[0]) begin n_fail++; $display("FAIL cont_order[%0d] got %0d want %0d", i, order[i], i[0]); end
        end
        wait_idle();
        n_cmp++; if (emitted.size() != 6) begin n_fail++; $display("FAIL cont_pulses got %0d want 6", emitted.size()); end
        for (int i = 0; i < 6 && i < emitted.size(); i++) begin
            n_cmp++; if (emitted[i] !== exp[i]) begin n_fail++; $display("FAIL cont_char[%0d] got %h want %h", i, emitted[i], exp[i]); end
        end
    endtask

    task automatic test_fairness();
        logic [7:0] exp[$] = '{8'h41, 8'h42, 8'h43, 8'h55, 8'h44};
        apply_reset();
        send(1'b0, 8'h41);
        send(1'b0, 8'h42);
        send(1'b0, 8'h43);
        a_valid = 1'b1; a_data = 8'h44; b_valid = 1'b1; b_data = 8'h55;
        #1;
        n_cmp++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL fair_b_ready got %b want 1", b_ready); end
        n_cmp++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL fair_a_ready got %b want 0", a_ready); end
        @(posedge clk); #1;
        b_valid = 1'b0;
        send(1'b0, 8'h44);
        wait_idle();
        n_cmp++; if (emitted.size() != 5) begin n_fail++; $display("FAIL fair_pulses got %0d want 5", emitted.size()); end
        for (int i = 0; i < 5 && i < emitted.size(); i++) begin
            n_cmp++; if (emitted[i] !== exp[i]) begin n_fail++; $display("FAIL fair_char[%0d] got %h want %h", i, emitted[i], exp[i]); end
        end
    endtask

    task automatic test_backpressure();
        int i = 0, t = 0, rule_err = 0;
        bit full_seen = 1'b0;
        logic [7:0] d;
        apply_reset();
        a_valid = 1'b1; a_data = 8'h60;
        while (i < 12 && t < 500) begin
            #1;
            if (fifo_count == 4'd8) begin
                full_seen = 1'b1;
                if (a_ready !== 1'b0) rule_err++;
            end else if (a_ready !== 1'b1) rule_err++;
            d = a_data;
            if (a_ready) i++;
            @(posedge clk); #1; t++;
            if (i < 12) a_data = 8'h60 + 8'(i); else a_valid = 1'b0;
        end
        a_valid = 1'b0;
        n_cmp++; if (full_seen !== 1'b1) begin n_fail++; $display("FAIL bp_full_seen got %b want 1", full_seen); end
        n_cmp++; if (rule_err != 0)      begin n_fail++; $display("FAIL bp_ready_rule got %0d errors want 0", rule_err); end
        n_cmp++; if (i != 12)            begin n_fail++; $display("FAIL bp_accepts got %0d want 12 last %h", i, d); end
        wait_idle();
        n_cmp++; if (emitted.size() != 12) begin n_fail++; $display("FAIL bp_pulses got %0d want 12", emitted.size()); end
        for (int k = 0; k < 12 && k < emitted.size(); k++) begin
            n_cmp++; if (emitted[k] !== 8'h60 + 8'(k)) begin n_fail++; $display("FAIL bp_char[%0d] got %h want %h", k, emitted[k], 8'h60 + 8'(k)); end
        end
    endtask

    task automatic test_crlf();
`ifdef VGA_TEXT_CRLF_COLLAPSE_EN
        logic [7:0] exp[$] = '{8'h0D, 8'h0A, 8'h41};
`else
        logic [7:0] exp[$] = '{8'h0D, 8'h0A, 8'h0A, 8'h41};
`endif
        apply_reset();
        send(1'b0, 8'h0D);
        send(1'b1, 8'h0A);
        send(1'b0, 8'h0A);
        send(1'b1, 8'h41);
        wait_idle();
        n_cmp++; if (emitted.size() != exp.size()) begin n_fail++; $display("FAIL crlf_pulses got %0d want %0d", emitted.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < emitted.size(); i++) begin
            n_cmp++; if (emitted[i] !== exp[i]) begin n_fail++; $display("FAIL crlf_char[%0d] got %h want %h", i, emitted[i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid_pulse();
        int t = 0;
        apply_reset();
        for (int i = 0; i < 5; i++) send(1'b0, 8'h70 + 8'(i));
        #1;
        while (!(en && fifo_count == 4'd3) && t < 60) begin @(posedge clk); #2; t++; end
        n_cmp++; if (t >= 60) begin n_fail++; $display("FAIL midrst_setup en=%b count=%0d want en=1 count=3", en, fifo_count); end
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (en !== 1'b0)         begin n_fail++; $display("FAIL midrst_en got %b want 0", en); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", fifo_count); end
        n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        emitted.delete();
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (emitted.size() != 0) begin n_fail++; $display("FAIL midrst_quiet got %0d pulses want 0", emitted.size()); end
        n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL midrst_quiet_busy got %b want 0", busy); end
        send(1'b1, 8'h5A);
        wait_idle();
        n_cmp++; if (emitted.size() != 1) begin n_fail++; $display("FAIL midrst_after_pulses got %0d want 1", emitted.size()); end
        else begin
            n_cmp++; if (emitted[0] !== 8'h5A) begin n_fail++; $display("FAIL midrst_after_char got %h want 5a", emitted[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_contention();
        test_fairness();
        test_backpressure();
        test_crlf();
        test_reset_mid_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
